// File: rtl/gpu_upload_dma.sv
// gpu_upload_dma: Wishbone master that copies a block of 32-bit words from a
// synchronous source RAM into the GPU slave address space.
//
// Each word takes a FETCH (RAM read), a LATCH (capture data/address) and a
// WRITE (classic single write held until ack). cyc stays high across the whole
// block; stb is only high while a write is outstanding. A stalled slave is cut
// off after TIMEOUT cycles with a sticky error.
//
// Ports:
//   clk_100MHz, reset          clock, asynchronous active-high reset
//   i_start, i_abort           start pulse (IDLE only), abort (non-IDLE only)
//   i_src_base, i_dst_base     first source word address, first GPU byte address
//   i_word_cnt, i_sel          words to move (0 legal), byte select for every write
//   o_src_re, o_src_addr       source RAM read port; i_src_rdata valid one cycle later
//   wb_*                       Wishbone master signals
//   o_busy, o_done, o_err      status: not idle, completion pulse, sticky timeout
module gpu_upload_dma #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_src_base,
    input  logic [26:0]      i_dst_base,
    input  logic [CNT_W-1:0] i_word_cnt,
    input  logic [3:0]       i_sel,
    output logic             o_src_re,
    output logic [CNT_W-1:0] o_src_addr,
    input  logic [31:0]      i_src_rdata,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [26:0]      wb_adr_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_ack_i,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th unacked cycle aborts.
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StWrite,
        StDone
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] src_q;
    logic [26:0]      dst_q;
    logic [CNT_W-1:0] rem_q;
    logic [TmoW-1:0]  tmo_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            o_src_re   <= 1'b0;
            o_src_addr <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_sel_o   <= '0;
            wb_dat_o   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state_q != StIdle && i_abort) begin
                // Abort wins over a same-cycle ack: pointers are left untouched.
                state_q  <= StIdle;
                o_busy   <= 1'b0;
                o_src_re <= 1'b0;
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_start) begin
                            src_q    <= i_src_base;
                            dst_q    <= i_dst_base;
                            rem_q    <= i_word_cnt;
                            wb_sel_o <= i_sel;
                            o_err    <= 1'b0;
                            o_busy   <= 1'b1;
                            if (i_word_cnt == '0) begin
                                state_q <= StDone;
                                o_done  <= 1'b1;
                            end else begin
                                state_q    <= StFetch;
                                o_src_re   <= 1'b1;
                                o_src_addr <= i_src_base;
                            end
                        end
                    end
                    StFetch: begin
                        o_src_re <= 1'b0;
                        state_q  <= StLatch;
                    end
                    StLatch: begin
                        wb_dat_o <= i_src_rdata;
                        wb_adr_o <= dst_q;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        tmo_q    <= '0;
                        state_q  <= StWrite;
                    end
                    StWrite: begin
                        if (wb_ack_i) begin
                            src_q    <= src_q + CNT_W'(1);
                            dst_q    <= dst_q + 27'd4;
                            rem_q    <= rem_q - CNT_W'(1);
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            if (rem_q == CNT_W'(1)) begin
                                wb_cyc_o <= 1'b0;
                                o_done   <= 1'b1;
                                state_q  <= StDone;
                            end else begin
                                // cyc stays up between words of the block.
                                o_src_re   <= 1'b1;
                                o_src_addr <= src_q + CNT_W'(1);
                                state_q    <= StFetch;
                            end
                        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            o_err    <= 1'b1;
                            o_done   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            tmo_q <= tmo_q + TmoW'(1);
                        end
                    end
                    StDone: begin
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/gpu_upload_dma.md
# gpu_upload_dma

Wishbone master DMA engine that sits directly upstream of the GPU top-level slave port (wb_* inputs). It copies a block of 32-bit words from a synchronous source RAM, such as the CPU-side staging buffer, into the GPU address space (control registers, sprite positions, tile map, texture memory). The CPU does not poke each word itself. Transfers are single classic Wishbone write cycles held inside one continuous bus cycle, with ack timeout protection.

## Interface
Parameters:
- CNT_W, 16: width of word count and source address.
- TIMEOUT, 255: max cycles stb may wait for ack before error abort.

Ports:
- clk_100MHz  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_abort  in  1  abort the current transfer; ignored in IDLE.
- i_src_base  in  CNT_W  first source word address.
- i_dst_base  in  27  first GPU byte address; bits [1:0] must be 0.
- i_word_cnt  in  CNT_W  number of words; 0 is legal.
- i_sel  in  4  byte select driven on every write.
- o_src_re  out  1  source RAM read enable.
- o_src_addr  out  CNT_W  source RAM word address.
- i_src_rdata  in  32  source data, valid one cycle after o_src_re.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_adr_o  out  27  GPU byte address.
- wb_sel_o  out  4  byte select.
- wb_dat_o  out  32  write data.
- wb_ack_i  in  1  slave acknowledge.
- o_busy  out  1  high whenever the engine is not in IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky timeout flag; cleared by the next accepted start.

## Operation
- States: IDLE, FETCH, LATCH, WRITE, DONE.
- IDLE + i_start:
  - Latch src pointer, dst pointer, remaining count, and sel.
  - Clear o_err.
  - If i_word_cnt==0, go to DONE with no bus activity. Otherwise go to FETCH.
- FETCH:
  - o_src_re=1 and o_src_addr=src pointer.
  - Go to LATCH.
- LATCH:
  - Register i_src_rdata into wb_dat_o and the dst pointer into wb_adr_o.
  - Go to WRITE.
- WRITE:
  - wb_cyc_o=wb_stb_o=wb_we_o=1.
  - Hold wb_adr_o, wb_dat_o and wb_sel_o stable until ack.
  - On wb_stb_o & wb_ack_i: src pointer +1, dst pointer +4, remaining -1. If remaining was 1, go to DONE; else go to FETCH.
- DONE:
  - o_done=1 for exactly one cycle, then return to IDLE.
- wb_cyc_o stays high from the first WRITE cycle until the last ack, including the FETCH and LATCH cycles between words. wb_stb_o is high only in WRITE.
- Timeout:
  - A counter runs while in WRITE without ack and is cleared on entry to WRITE.
  - When the count reaches TIMEOUT, drop cyc and stb, set o_err=1, and go to DONE.
- Abort:
  - Any non-IDLE state returns to IDLE on the next edge.
  - cyc and stb drop at that edge.
  - No o_done pulse; o_err is unchanged.
- i_abort has priority over a same-cycle wb_ack_i. The acked word counts as written by the slave, but the engine does not advance.
- i_start while busy is ignored, and inputs are not re-latched.
- Pointer arithmetic: src wraps modulo 2^CNT_W and dst wraps modulo 2^27, silently.

## Timing
- Reset values:
  - o_busy, o_done, o_err, o_src_re = 0.
  - wb_cyc_o, wb_stb_o, wb_we_o = 0.
  - wb_adr_o, wb_dat_o, o_src_addr = 0.
  - wb_sel_o = 0.
- Reset asserted mid-transfer forces IDLE immediately and asynchronously, dropping cyc and stb.
- Start accepted at edge T:
  - o_busy=1 and FETCH from T+1.
  - First stb at T+3.
- Cost per word: 2 + (ack wait + 1) cycles. With ack in the first WRITE cycle, that is 3 cycles/word.
- Last ack at edge A: o_done high in cycle A+1 and o_busy low from A+2.
- Zero-count start at T: o_done in cycle T+1, with no cyc.
- All outputs are registered; there are no combinational paths from wb_ack_i to outputs.

## Test plan
- Copy 4 words, src_base=0x10, dst_base=0x1000, ack every cycle.
  - Writes land at 0x1000, 0x1004, 0x1008, 0x100C in order with the source data.
  - o_done occurs 12 cycles after the first FETCH.
  - Word spacing is 3 cycles and cyc is continuous.
- Slave model that acks on alternate cycles (the 50 MHz enable pattern), 8 words.
  - Data and addresses stay stable until each ack.
  - Correct data arrives and there are no duplicate writes.
- i_word_cnt=0.
  - o_done pulses one cycle after start.
  - cyc is never asserted and o_err=0.
- Slave never acks, TIMEOUT=255.
  - stb is held for exactly 255 cycles and then drops.
  - o_err=1 and o_done pulses.
  - A following start clears o_err.
- Abort during the second WRITE of a 6-word transfer, including the abort coinciding with ack.
  - cyc/stb drop on the next edge and o_busy goes to 0.
  - There is no o_done pulse and no further writes.
- Async reset mid-WRITE, then a start pulse while busy.
  - Reset: all outputs are 0 immediately.
  - Start while busy: the second start is ignored and the first transfer completes unchanged.
